// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: register-file geometry and the write-back entry type shared with decode.
package writeback_arbiter_pkg;
    localparam int REG_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam int RSTATUS_REG = 30;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_W-1:0]      data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular result buffer for the mult/div write-back path.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      ctrl_reset_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);
    wb_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic do_push, do_pop;
    assign full = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    // Pointers wrap by natural overflow since DEPTH is a power of two.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and mult/div results onto the register-file write port.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RSTATUS_REG = 30
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [REG_W-1:0]      alu_data,
    input  logic                  alu_exc,
    input  logic [REG_W-1:0]      alu_exc_code,
    input  logic                  md_issue_valid,
    input  logic [REG_ADDR_W-1:0] md_issue_rd,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [REG_W-1:0]      md_data,
    output logic                  md_ready,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [REG_W-1:0]      data_writeReg,
    output logic [NUM_REGS-1:0]   busy
);
    wb_entry_t head, sel;
    logic full, empty, pop, sel_valid, sel_write;
    logic [NUM_REGS-1:0] busy_next;
    assign md_ready = !full;
    assign pop = !alu_valid && !empty;
    assign sel_valid = alu_valid || !empty;
    assign sel_write = sel_valid && sel.rd != '0;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .ctrl_reset_n(ctrl_reset_n),
        .push(md_valid),
        .push_entry({md_rd, md_data}),
        .pop(pop),
        .head(head),
        .full(full),
        .empty(empty)
    );
    // The ALU cannot stall, so it always wins; exceptions redirect to the status register.
    always_comb begin
        sel = head;
        if (alu_valid) sel = {alu_exc ? REG_ADDR_W'(RSTATUS_REG) : alu_rd, alu_exc ? alu_exc_code : alu_data};
    end
    // Issue is applied after the pop clear so a same-edge set wins.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head.rd] = 1'b0;
        if (md_issue_valid) busy_next[md_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg <= '0;
            data_writeReg <= '0;
            busy <= '0;
        end else begin
            ctrl_writeEnable <= sel_write;
            if (sel_write) {ctrl_writeReg, data_writeReg} <= sel;
            busy <= busy_next;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: randomized and directed checks against a queue-based write-back model.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;
    localparam int DEPTH = 2;
    logic clock = 1'b0;
    logic ctrl_reset_n = 1'b0;
    logic alu_valid, alu_exc, md_issue_valid, md_valid;
    logic [4:0] alu_rd, md_issue_rd, md_rd;
    logic [31:0] alu_data, alu_exc_code, md_data;
    logic md_ready, ctrl_writeEnable;
    logic [4:0] ctrl_writeReg;
    logic [31:0] data_writeReg, busy;
    always #5 clock = ~clock;
    writeback_arbiter #(.DEPTH(DEPTH), .RSTATUS_REG(30)) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_exc(alu_exc), .alu_exc_code(alu_exc_code),
        .md_issue_valid(md_issue_valid), .md_issue_rd(md_issue_rd),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .busy(busy)
    );
    wb_entry_t q[$];
    logic m_we, m_chk_addr, acc;
    logic [4:0] m_reg;
    logic [31:0] m_data, m_busy;
    int n_cmp = 0;
    int n_bad = 0;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        m_we = 0; m_reg = 0; m_data = 0; m_busy = 0; m_chk_addr = 1;
    endtask
    task automatic idle();
        alu_valid = 0; alu_exc = 0; alu_rd = 0; alu_data = 0; alu_exc_code = 0;
        md_issue_valid = 0; md_issue_rd = 0; md_valid = 0; md_rd = 0; md_data = 0;
    endtask
    // Model one clock: ALU beats FIFO head, r0 writes vanish, issue beats pop-clear.
    task automatic step();
        wb_entry_t sel;
        bit have;
        #1;
        check("md_ready", md_ready, q.size() < DEPTH);
        acc = md_valid && q.size() < DEPTH;
        have = 1;
        sel = '0;
        if (alu_valid) begin
            sel.rd = alu_exc ? 5'd30 : alu_rd;
            sel.data = alu_exc ? alu_exc_code : alu_data;
        end else if (q.size() > 0) begin
            sel = q.pop_front();
            m_busy[sel.rd] = 1'b0;
        end else have = 0;
        if (md_issue_valid) m_busy[md_issue_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (acc) q.push_back({md_rd, md_data});
        m_we = have && sel.rd != 0;
        if (m_we) begin
            m_reg = sel.rd;
            m_data = sel.data;
        end
        m_chk_addr = m_we || !have;
        @(posedge clock);
        #1;
        check("we", ctrl_writeEnable, m_we);
        check("busy", busy, m_busy);
        if (m_chk_addr) begin
            check("reg", ctrl_writeReg, m_reg);
            check("data", data_writeReg, m_data);
        end
    endtask
    task automatic async_reset();
        #2;
        ctrl_reset_n = 0;
        #1;
        check("rst_we", ctrl_writeEnable, 0);
        check("rst_reg", ctrl_writeReg, 0);
        check("rst_data", data_writeReg, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", md_ready, 1);
        model_reset();
        @(posedge clock);
        #2;
        ctrl_reset_n = 1;
    endtask
    initial begin
        wb_entry_t res [3];
        int k;
        idle();
        @(posedge clock);
        @(posedge clock);
        #1;
        check("init_we", ctrl_writeEnable, 0);
        check("init_reg", ctrl_writeReg, 0);
        check("init_data", data_writeReg, 0);
        check("init_busy", busy, 0);
        check("init_ready", md_ready, 1);
        model_reset();
        ctrl_reset_n = 1;
        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        check("alu_we", ctrl_writeEnable, 1);
        check("alu_reg", ctrl_writeReg, 5);
        check("alu_data", data_writeReg, 32'hDEADBEEF);
        idle();
        step();
        check("alu_we_off", ctrl_writeEnable, 0);
        // Mult/div issue, result, scoreboard clear
        md_issue_valid = 1; md_issue_rd = 7;
        step();
        idle();
        check("busy7_set", busy[7], 1);
        md_valid = 1; md_rd = 7; md_data = 32'h12345678;
        step();
        idle();
        check("md_not_yet", ctrl_writeEnable, 0);
        check("busy7_held", busy[7], 1);
        step();
        check("md_we", ctrl_writeEnable, 1);
        check("md_reg", ctrl_writeReg, 7);
        check("md_data", data_writeReg, 32'h12345678);
        check("busy7_clr", busy[7], 0);
        // ALU starvation with three offered results
        res[0] = {5'd20, 32'hA0}; res[1] = {5'd21, 32'hA1}; res[2] = {5'd22, 32'hA2};
        k = 0;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = i;
            md_valid = k < 3; {md_rd, md_data} = res[k < 3 ? k : 2];
            step();
            check("alu_b2b", ctrl_writeEnable, 1);
            if (acc) k++;
        end
        check("full_ready", md_ready, 0);
        alu_valid = 0;
        for (int g = 0; g < 20 && (k < 3 || q.size() > 0); g++) begin
            md_valid = k < 3; {md_rd, md_data} = res[k < 3 ? k : 2];
            step();
            if (g == 0) check("drain_first", ctrl_writeReg, 20);
            if (acc) k++;
        end
        check("drain_done", k + q.size(), 3);
        idle();
        // Exception redirects to r30
        alu_valid = 1; alu_exc = 1; alu_rd = 3; alu_exc_code = 32'h4;
        step();
        check("exc_reg", ctrl_writeReg, 30);
        check("exc_data", data_writeReg, 4);
        idle();
        // r0 from both producers
        md_valid = 1; md_rd = 0; md_data = 32'h55;
        step();
        idle();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h66;
        step();
        check("r0_alu", ctrl_writeEnable, 0);
        idle();
        step();
        check("r0_md", ctrl_writeEnable, 0);
        check("r0_empty", md_ready, 1);
        // Async reset with a full FIFO
        md_issue_valid = 1; md_issue_rd = 9;
        step();
        md_issue_valid = 0;
        alu_valid = 1; alu_rd = 1; md_valid = 1; md_rd = 9; md_data = 32'h99;
        step();
        step();
        check("pre_rst_busy9", busy[9], 1);
        check("pre_rst_full", md_ready, 0);
        async_reset();
        idle();
        step();
        check("post_rst_we", ctrl_writeEnable, 0);
        // Randomized traffic; the mult/div producer holds its offer until accepted
        for (int c = 0; c < 3000; c++) begin
            alu_valid = $urandom_range(0, 2) == 0;
            alu_exc = $urandom_range(0, 7) == 0;
            alu_rd = 5'($urandom); alu_data = $urandom; alu_exc_code = $urandom;
            md_issue_valid = $urandom_range(0, 3) == 0;
            md_issue_rd = 5'($urandom);
            if (!md_valid || acc) begin
                md_valid = $urandom_range(0, 1) == 1;
                md_rd = 5'($urandom); md_data = $urandom;
            end
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side initiator for the 32x32 register file: drives ctrl_writeEnable / ctrl_writeReg / data_writeReg from two producers.
- Producer 1: single-cycle ALU path, which cannot stall.
- Producer 2: multi-cycle mult/div path, with valid/ready backpressure and a small result FIFO.
- Also keeps a per-register busy scoreboard of outstanding mult/div destinations, read by the stall logic.

Parameters:
- DEPTH, 2, mult/div result FIFO entries (power of two, ≥2).
- RSTATUS_REG, 30, destination register for ALU exception codes.

Ports:
- clock  in  1  rising-edge clock.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_exc  in  1  exception flag; qualified by alu_valid.
- alu_exc_code  in  32  value written to RSTATUS_REG on exception.
- md_issue_valid  in  1  mult/div op issued this cycle.
- md_issue_rd  in  5  destination of the issued op.
- md_valid  in  1  mult/div result offered.
- md_rd  in  5  mult/div result destination.
- md_data  in  32  mult/div result.
- md_ready  out  1  FIFO can accept a result (combinational: count < DEPTH).
- ctrl_writeEnable  out  1  registered regfile write enable.
- ctrl_writeReg  out  5  registered write address.
- data_writeReg  out  32  registered write data.
- busy  out  32  registered scoreboard; bit i set means a mult/div write to ri is outstanding.

Behaviour:
- Reset (async, ctrl_reset_n=0):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, busy=0.
  - FIFO empty, count=0, so md_ready=1.
  - Reset mid-operation discards FIFO contents and busy bits; no write is issued on the release edge.
- MD handshake:
  - Transfer when md_valid && md_ready at a rising edge; the entry is pushed to FIFO tail.
  - md_valid with md_ready=0: no transfer; the producer holds its value.
- Per-cycle selection (exactly one candidate; result registered to the outputs on the next edge):
  - alu_valid=1: ALU wins. Write {rd, data} = alu_exc ? {RSTATUS_REG, alu_exc_code} : {alu_rd, alu_data}. FIFO head not popped.
  - else FIFO non-empty: pop head, write {head.rd, head.data}.
  - else: ctrl_writeEnable=0. ctrl_writeReg and data_writeReg hold their previous values.
- r0: a selected candidate with rd=0 is consumed (popped if from FIFO) but drives ctrl_writeEnable=0.
- Latency:
  - ALU input at edge N: write visible after edge N+1 (1 cycle).
  - MD accepted at edge N: earliest write after edge N+2.
  - With continuous ALU traffic the FIFO starves (intended; the stall unit relies on busy).
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers wrapping mod DEPTH; count width log2(DEPTH)+1.
  - Push and pop in the same cycle is legal when not full; count is unchanged.
  - Full: md_ready=0, no push. Empty: no pop.
- Scoreboard:
  - Set busy[md_issue_rd] on md_issue_valid.
  - Clear busy[rd] on the edge a FIFO-sourced write to rd is registered (including an rd=0 drop).
  - Same register set and cleared on the same edge: set wins.
  - busy[0] is always 0.
  - ALU writes never change busy.
- ALU exception with alu_rd=0 still writes RSTATUS_REG (exception path ignores alu_rd).
- Ordering: the FIFO preserves mult/div completion order; there is no reordering between FIFO entries.

Decomposition:
- Shared package: REG_W=32, REG_ADDR_W=5, NUM_REGS=32, RSTATUS_REG=30, and the wb_entry typedef {rd[4:0], data[31:0]}. The core's decode logic reuses these.
- One natural sub-module: wb_fifo (parameterised DEPTH; push/pop/full/empty/head). The arbiter and scoreboard stay in the top module.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle → after the next edge: ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; the following cycle ctrl_writeEnable=0.
- md_issue rd=7, then md result {7, 0x12345678} accepted with ALU idle:
  - busy[7]=1 from issue until the write edge;
  - write appears 2 cycles after acceptance;
  - busy[7]=0 after the write edge.
- ALU valid every cycle for 4 cycles while md offers 3 results:
  - first 2 accepted, md_ready=0 with the third held;
  - ALU writes occur back-to-back;
  - FIFO entries then drain in order, after which the third is accepted.
- alu_valid=1, alu_exc=1, alu_rd=3, alu_exc_code=0x4 → write r30=0x4; r3 is not written.
- md result to rd=0 and alu_rd=0 → no ctrl_writeEnable pulse; FIFO count returns to 0.
- Full FIFO with busy[9]=1, ctrl_reset_n pulsed low asynchronously mid-cycle → all outputs 0 immediately, md_ready=1, no write after release.
